// File: rtl/mac_row_ctrl_if.sv
// mac_row_ctrl_if: bundles the job, weight-load, activation-stream and
// mac_row strobe signals between the row controller and its environment.
// The master modport is the controller side; the slave modport is the
// environment side (job source, weight buffer, activation source, mac_row).
interface mac_row_ctrl_if #(
    parameter int bw      = 4,
    parameter int npair_w = 8
);
    // job control
    logic                 start;
    logic [npair_w-1:0]   num_pairs;
    logic                 busy;
    logic                 done;
    // weight-load handshake
    logic                 wload_req;
    logic                 wload_ack;
    // activation-pair stream
    logic                 act_valid;
    logic                 act_ready;
    logic [2*bw-1:0]      act_data;
    logic [3:0]           act_idx;
    // mac_row control
    logic                 load;
    logic                 execute;
    logic                 a_select;
    logic                 acc_done;
    logic [2*bw-1:0]      mac_act;
    logic [3:0]           mac_idx;
    logic                 load_out;
    // status
    logic                 err;

    modport master (
        input  start, num_pairs, wload_ack, act_valid, act_data, act_idx, load_out,
        output busy, done, wload_req, act_ready, load, execute, a_select,
               acc_done, mac_act, mac_idx, err
    );

    modport slave (
        output start, num_pairs, wload_ack, act_valid, act_data, act_idx, load_out,
        input  busy, done, wload_req, act_ready, load, execute, a_select,
               acc_done, mac_act, mac_idx, err
    );
endinterface

// File: rtl/mac_row_ctrl.sv
// mac_row_ctrl: sequences one mac_row job -- weight load, then one
// fetch/execute pass per activation pair, then wait for the row's partial
// sum (load_out) before pulsing done.
//
// Optional feature: define MAC_CTRL_TIMEOUT_EN to add a drain watchdog.
// With it, 255 cycles in DRAIN without load_out set the sticky err flag
// and force the job to DONE. Without it, DRAIN waits forever and err is 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; num_pairs latched on accept
// S_WLOAD | wload_req high until the weight buffer acks
// S_LOAD  | one-cycle load strobe to mac_row
// S_FETCH | act_ready high; capture an activation pair on valid
// S_EXEC  | one-cycle execute strobe; pair counter advances
// S_DRAIN | wait for mac_row load_out (optionally bounded)
// S_DONE  | one-cycle done / acc_done pulse
module mac_row_ctrl #(
    parameter int bw      = 4,
    parameter int npair_w = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    mac_row_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_LOAD  = 3'd2,
        S_FETCH = 3'd3,
        S_EXEC  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [npair_w-1:0]   r_num_pairs;
    logic [npair_w-1:0]   r_count;
    logic [npair_w-1:0]   w_count_inc;
    logic                 r_a_select;
    logic [2*bw-1:0]      r_mac_act;
    logic [3:0]           r_mac_idx;

    logic                 w_job_accept;
    logic                 w_act_accept;
    logic                 w_last_pair;
    logic                 w_drain_timeout;

    logic                 w_busy;
    logic                 w_done;
    logic                 w_wload_req;
    logic                 w_act_ready;
    logic                 w_load;
    logic                 w_execute;

    // A zero-pair job skips straight to DONE and never touches the datapath.
    assign w_job_accept = (r_state == S_IDLE) && bus.start && (bus.num_pairs != '0);
    assign w_act_accept = (r_state == S_FETCH) && bus.act_valid;
    assign w_count_inc  = r_count + 1'b1;
    // Equality against the latched count; the counter stops at num_pairs and never wraps.
    assign w_last_pair  = (w_count_inc == r_num_pairs);

`ifdef MAC_CTRL_TIMEOUT_EN
    logic [7:0] r_drain_cnt;
    logic       r_err;

    // Drain watchdog: reload when entering DRAIN, count down while waiting;
    // terminal count 0 is reached on the 255th DRAIN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drain_cnt <= '0;
        end else if ((r_state == S_EXEC) && w_last_pair) begin
            r_drain_cnt <= 8'd254;
        end else if ((r_state == S_DRAIN) && (r_drain_cnt != 8'd0)) begin
            r_drain_cnt <= r_drain_cnt - 8'd1;
        end
    end

    assign w_drain_timeout = (r_state == S_DRAIN) && !bus.load_out && (r_drain_cnt == 8'd0);

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_drain_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_drain_timeout = 1'b0;
    assign bus.err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore-decoded strobes.
    always_comb begin
        w_next      = r_state;
        w_busy      = (r_state != S_IDLE);
        w_done      = 1'b0;
        w_wload_req = 1'b0;
        w_act_ready = 1'b0;
        w_load      = 1'b0;
        w_execute   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num_pairs != '0) ? S_WLOAD : S_DONE;
                end
            end
            S_WLOAD: begin
                w_wload_req = 1'b1;
                if (bus.wload_ack) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_act_ready = 1'b1;
                if (bus.act_valid) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_execute = 1'b1;
                w_next    = w_last_pair ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: begin
                if (bus.load_out || w_drain_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job registers: latch the pair count at job accept; advance the pair
    // counter and flip the accumulator select once per executed pair.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num_pairs <= '0;
            r_count     <= '0;
            r_a_select  <= 1'b0;
        end else if (w_job_accept) begin
            r_num_pairs <= bus.num_pairs;
            r_count     <= '0;
            r_a_select  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_count     <= w_count_inc;
            r_a_select  <= ~r_a_select;
        end
    end

    // Activation pair held for mac_row; only an accepted FETCH handshake updates it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mac_act <= '0;
            r_mac_idx <= '0;
        end else if (w_act_accept) begin
            r_mac_act <= bus.act_data;
            r_mac_idx <= bus.act_idx;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.acc_done  = w_done;
    assign bus.wload_req = w_wload_req;
    assign bus.act_ready = w_act_ready;
    assign bus.load      = w_load;
    assign bus.execute   = w_execute;
    assign bus.a_select  = r_a_select;
    assign bus.mac_act   = r_mac_act;
    assign bus.mac_idx   = r_mac_idx;

endmodule

// File: tb/tb_mac_row_ctrl.sv
// tb_mac_row_ctrl: directed bench for mac_row_ctrl. Each activation pair
// pushed onto the stream also pushes its expected mac_act/mac_idx/a_select
// onto a scoreboard; a negedge monitor pops one entry per execute strobe.
// Honours MAC_CTRL_TIMEOUT_EN the same way as the design.
module tb_mac_row_ctrl;

    typedef struct {
        logic [7:0] act;
        logic [3:0] idx;
        logic       asel;
    } exp_t;

    logic clk;
    logic rst;

    mac_row_ctrl_if #(.bw(4), .npair_w(8)) bus ();

    mac_row_ctrl #(.bw(4), .npair_w(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   exec_cnt  = 0;
    int   done_cnt  = 0;
    int   njob      = 0;
    int   pidx      = 0;
    int   seed      = 0;
    exp_t sb[$];
    logic [7:0] last_act = 8'h00;
    logic [3:0] last_idx = 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present the next pair of the current job and record what mac_row must see.
    task automatic present();
        exp_t e;
        e.act = 8'(seed * 16 + pidx * 37 + 5);
        e.idx = 4'(seed + pidx * 5 + 3);
        e.asel = pidx[0];
        bus.act_data = e.act;
        bus.act_idx  = e.idx;
        sb.push_back(e);
        pidx++;
    endtask

    // One clock; inputs change and outputs are observed 1ns after the edge.
    task automatic step();
        logic acc;
        acc = bus.act_ready && bus.act_valid;
        if (acc) begin
            last_act = bus.act_data;
            last_idx = bus.act_idx;
        end
        @(posedge clk);
        #1;
        if (acc && pidx < njob) present();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_done"},      bus.done,      0);
        chk({tag, "_wload_req"}, bus.wload_req, 0);
        chk({tag, "_act_ready"}, bus.act_ready, 0);
        chk({tag, "_load"},      bus.load,      0);
        chk({tag, "_execute"},   bus.execute,   0);
        chk({tag, "_a_select"},  bus.a_select,  0);
        chk({tag, "_acc_done"},  bus.acc_done,  0);
        chk({tag, "_err"},       bus.err,       0);
        chk({tag, "_mac_act"},   bus.mac_act,   0);
        chk({tag, "_mac_idx"},   bus.mac_idx,   0);
    endtask

    // Scoreboard monitor: every execute must match the oldest presented pair.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) done_cnt++;
        if (bus.execute) begin
            exec_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_mac_act",  bus.mac_act,  e.act);
                chk("sb_mac_idx",  bus.mac_idx,  e.idx);
                chk("sb_a_select", bus.a_select, e.asel);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int d0;
        int nload;
        bit saw_done;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_pairs = '0;
        bus.wload_ack = 1'b0;
        bus.act_valid = 1'b0;
        bus.act_data  = '0;
        bus.act_idx   = '0;
        bus.load_out  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        step();
        chk("idle_busy", bus.busy, 0);

        // Job A: 3 pairs, ack and valid always high.
        seed = 1; njob = 3; pidx = 0;
        bus.wload_ack = 1'b1;
        bus.act_valid = 1'b1;
        present();
        e0 = exec_cnt; d0 = done_cnt; nload = 0;
        bus.num_pairs = 8'd3;
        bus.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) begin
                bus.start = 1'b0;
                chk("A_wload_req", bus.wload_req, 1);
            end
            if (bus.load) nload++;
            chk($sformatf("A_exec_c%0d", k), bus.execute, (k == 4 || k == 6 || k == 8));
            chk($sformatf("A_load_c%0d", k), bus.load, (k == 2));
            chk("A_busy", bus.busy, 1);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("A_drain_done", bus.done, 0);
            chk("A_drain_busy", bus.busy, 1);
        end
        bus.load_out = 1'b1;
        step();
        chk("A_done", bus.done, 1);
        chk("A_acc_done", bus.acc_done, 1);
        bus.load_out = 1'b0;
        step();
        chk("A_idle_busy", bus.busy, 0);
        chk("A_idle_done", bus.done, 0);
        chk("A_nload", nload, 1);
        chk("A_exec_count", exec_cnt - e0, 3);
        chk("A_done_count", done_cnt - d0, 1);
        chk("A_sb_empty", sb.size(), 0);

        // Job B: zero pairs -> done next cycle, nothing else.
        e0 = exec_cnt;
        bus.act_valid = 1'b0;
        bus.num_pairs = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("B_done", bus.done, 1);
        chk("B_acc_done", bus.acc_done, 1);
        chk("B_wload_req", bus.wload_req, 0);
        chk("B_load", bus.load, 0);
        chk("B_execute", bus.execute, 0);
        step();
        chk("B_idle_busy", bus.busy, 0);
        chk("B_exec_count", exec_cnt - e0, 0);

        // Job C: slow ack, data wiggle during load, 5 idle FETCH cycles,
        // start/num_pairs changes mid-job.
        seed = 2; njob = 2; pidx = 0;
        e0 = exec_cnt; d0 = done_cnt;
        bus.wload_ack = 1'b0;
        bus.load_out  = 1'b1;
        bus.act_data  = 8'hA5;
        bus.act_idx   = 4'hF;
        bus.num_pairs = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("C_wload_req1", bus.wload_req, 1);
        step();
        chk("C_wload_req2", bus.wload_req, 1);
        chk("C_load_early", bus.load, 0);
        bus.wload_ack = 1'b1;
        step();
        chk("C_load", bus.load, 1);
        bus.act_data  = 8'h3C;
        bus.act_idx   = 4'h9;
        bus.start     = 1'b1;
        bus.num_pairs = 8'd7;
        chk("C_act_hold_load", bus.mac_act, last_act);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("C_fetch_ready", bus.act_ready, 1);
            chk("C_fetch_noexec", bus.execute, 0);
            chk("C_fetch_act_hold", bus.mac_act, last_act);
            chk("C_fetch_idx_hold", bus.mac_idx, last_idx);
            if (i < 4) step();
        end
        present();
        bus.act_valid = 1'b1;
        step();
        chk("C_exec", bus.execute, 1);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && !bus.done; k++) step();
        chk("C_done", bus.done, 1);
        step();
        chk("C_idle_busy", bus.busy, 0);
        chk("C_exec_count", exec_cnt - e0, 2);
        chk("C_done_count", done_cnt - d0, 1);
        chk("C_sb_empty", sb.size(), 0);

        // Job D: 4 pairs, reset in EXEC of pair 2, then a fresh 1-pair job.
        seed = 3; njob = 4; pidx = 0;
        bus.load_out = 1'b0;
        present();
        d0 = done_cnt;
        bus.num_pairs = 8'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        chk("D_exec_pair2", bus.execute, 1);
        chk("D_asel_pair2", bus.a_select, 1);
        rst = 1'b1;
        #1;
        check_all_zero("D_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("D_no_done", done_cnt - d0, 0);
        rst = 1'b0;
        seed = 4; njob = 1; pidx = 0;
        bus.load_out = 1'b1;
        present();
        e0 = exec_cnt;
        bus.num_pairs = 8'd1;
        bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            chk($sformatf("D2_exec_c%0d", k), bus.execute, (k == 4));
            chk($sformatf("D2_done_c%0d", k), bus.done, (k == 6));
        end
        chk("D2_exec_count", exec_cnt - e0, 1);
        chk("D2_done_count", done_cnt - d0, 1);

        // Job E: load_out never arrives.
        seed = 5; njob = 1; pidx = 0;
        bus.load_out = 1'b0;
        present();
        bus.num_pairs = 8'd1;
        bus.start = 1'b1;
        saw_done = 1'b0;
        for (int k = 1; k <= 259; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (bus.done) saw_done = 1'b1;
        end
        chk("E_no_early_done", saw_done, 0);
        step();
`ifdef MAC_CTRL_TIMEOUT_EN
        chk("E_timeout_done", bus.done, 1);
        chk("E_timeout_err", bus.err, 1);
        step();
        chk("E_err_sticky", bus.err, 1);
        chk("E_idle_busy", bus.busy, 0);
`else
        chk("E_wait_done", bus.done, 0);
        chk("E_wait_err", bus.err, 0);
        repeat (40) step();
        chk("E_wait_busy", bus.busy, 1);
`endif
        rst = 1'b1;
        #1;
        chk("E_rst_err", bus.err, 0);
        chk("E_rst_busy", bus.busy, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
